sc_backg_lane_scheduler: RTL and testbench

Sequencer and arbiter for a bank of LANES background-type shift registers in the Frogger datapath. It drives the shared clear/load strobes and one 2-bit shift selection per lane, so each background lane scrolls left or right at its own programmable rate derived from a level-dependent base tick. It sits between game control (start/stop/pause/level) and the lane registers.

---
 rtl/sc_backg_lane_scheduler_if.sv | 70 +++++++
 rtl/sc_backg_lane_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_sc_backg_lane_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sc_backg_lane_scheduler_if.sv
// -----------------------------------------------------------------------------
// sc_backg_lane_scheduler_if
//
// Purpose : Bundles the game-control and lane-register signals of the
//           background lane scheduler into one interface.
//
// Parameter:
//   LANES  number of controlled lane registers. It must match the LANES
//          parameter of sc_backg_lane_scheduler.
//
// Signals (direction as seen by the scheduler):
//   SC_BACKGSCHED_start_InHigh          in   one-cycle start request
//   SC_BACKGSCHED_stop_InHigh           in   one-cycle abort to IDLE
//   SC_BACKGSCHED_pause_InHigh          in   level, freezes scrolling
//   SC_BACKGSCHED_level_In              in   speed level (base period shift)
//   SC_BACKGSCHED_direction_In          in   per lane: 0 = left, 1 = right
//   SC_BACKGSCHED_lanediv_InBUS         in   per lane 4-bit tick divider
//   SC_BACKGSCHED_clear_OutLow          out  shared clear, active low
//   SC_BACKGSCHED_load_OutLow           out  shared load, active low
//   SC_BACKGSCHED_shiftselection_OutBUS out  per lane 2-bit shift select
//   SC_BACKGSCHED_state_Out             out  IDLE=0 LOAD=1 RUN=2 PAUSED=3
//   SC_BACKGSCHED_steps_Out             out  base ticks taken in RUN
//
// Modports:
//   master  game-control side (drives requests, observes the scheduler)
//   slave   scheduler side
// -----------------------------------------------------------------------------
interface sc_backg_lane_scheduler_if #(
    parameter int LANES = 4
);
    logic                   SC_BACKGSCHED_start_InHigh;
    logic                   SC_BACKGSCHED_stop_InHigh;
    logic                   SC_BACKGSCHED_pause_InHigh;
    logic [1:0]             SC_BACKGSCHED_level_In;
    logic [LANES-1:0]       SC_BACKGSCHED_direction_In;
    logic [4*LANES-1:0]     SC_BACKGSCHED_lanediv_InBUS;
    logic                   SC_BACKGSCHED_clear_OutLow;
    logic                   SC_BACKGSCHED_load_OutLow;
    logic [2*LANES-1:0]     SC_BACKGSCHED_shiftselection_OutBUS;
    logic [1:0]             SC_BACKGSCHED_state_Out;
    logic [15:0]            SC_BACKGSCHED_steps_Out;

    modport master (
        output SC_BACKGSCHED_start_InHigh,
        output SC_BACKGSCHED_stop_InHigh,
        output SC_BACKGSCHED_pause_InHigh,
        output SC_BACKGSCHED_level_In,
        output SC_BACKGSCHED_direction_In,
        output SC_BACKGSCHED_lanediv_InBUS,
        input  SC_BACKGSCHED_clear_OutLow,
        input  SC_BACKGSCHED_load_OutLow,
        input  SC_BACKGSCHED_shiftselection_OutBUS,
        input  SC_BACKGSCHED_state_Out,
        input  SC_BACKGSCHED_steps_Out
    );

    modport slave (
        input  SC_BACKGSCHED_start_InHigh,
        input  SC_BACKGSCHED_stop_InHigh,
        input  SC_BACKGSCHED_pause_InHigh,
        input  SC_BACKGSCHED_level_In,
        input  SC_BACKGSCHED_direction_In,
        input  SC_BACKGSCHED_lanediv_InBUS,
        output SC_BACKGSCHED_clear_OutLow,
        output SC_BACKGSCHED_load_OutLow,
        output SC_BACKGSCHED_shiftselection_OutBUS,
        output SC_BACKGSCHED_state_Out,
        output SC_BACKGSCHED_steps_Out
    );
endinterface

// File: rtl/sc_backg_lane_scheduler.sv
// -----------------------------------------------------------------------------
// sc_backg_lane_scheduler
//
// Purpose : Sequencer/arbiter for the bank of background-type lane shift
//           registers. Produces the shared clear/load strobes and one 2-bit
//           shift selection per lane so that every lane scrolls at its own
//           rate: lane i shifts once every div_i base ticks, and the base tick
//           period is P = max(1, TICK_PERIOD >> level) clocks.
//
// Parameters:
//   LANES            number of lane registers
//   TICK_PERIOD      base tick period in clocks at level 0
//   PRESCALER_WIDTH  width of the base-tick prescaler
//
// Ports:
//   SC_RegBACKGTYPE_CLOCK_50      system clock, rising edge
//   SC_RegBACKGTYPE_RESET_InHigh  asynchronous reset, active high
//   schedBus                      sc_backg_lane_scheduler_if.slave
//                                 (control inputs and all registered outputs)
//
// Build option:
//   SC_BACKGSCHED_ROUNDROBIN_EN   when defined, at most one lane shifts per
//                                 clock; due lanes are queued as pending flags
//                                 and granted round-robin. When undefined all
//                                 lanes due on a tick shift together.
// -----------------------------------------------------------------------------
module sc_backg_lane_scheduler #(
    parameter int LANES           = 4,
    parameter int TICK_PERIOD     = 6250000,
    parameter int PRESCALER_WIDTH = 32
) (
    input logic                       SC_RegBACKGTYPE_CLOCK_50,
    input logic                       SC_RegBACKGTYPE_RESET_InHigh,
    sc_backg_lane_scheduler_if.slave  schedBus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        PAUSED = 2'd3
    } schedState_t;

    localparam logic [PRESCALER_WIDTH-1:0] PRESCALER_ZERO  = {PRESCALER_WIDTH{1'b0}};
    localparam logic [PRESCALER_WIDTH-1:0] PRESCALER_ONE   = PRESCALER_WIDTH'(1);
    localparam logic [PRESCALER_WIDTH-1:0] TICK_PERIOD_VEC = PRESCALER_WIDTH'(TICK_PERIOD);

    // Shift-select code for one lane: left = 2'b01, right = 2'b10.
    function automatic logic [1:0] dirCode(input logic dirRight);
        logic [1:0] code;
        if (dirRight) begin
            code = 2'b10;
        end else begin
            code = 2'b01;
        end
        return code;
    endfunction

    // Local aliases for the control inputs.
    logic               startReq;
    logic               stopReq;
    logic               pauseReq;
    logic [LANES-1:0]   dirVec;

    assign startReq = schedBus.SC_BACKGSCHED_start_InHigh;
    assign stopReq  = schedBus.SC_BACKGSCHED_stop_InHigh;
    assign pauseReq = schedBus.SC_BACKGSCHED_pause_InHigh;
    assign dirVec   = schedBus.SC_BACKGSCHED_direction_In;

    schedState_t                stateReg;
    schedState_t                stateNext;
    logic                       clearReg;
    logic                       loadReg;
    logic [2*LANES-1:0]         shiftReg;
    logic [2*LANES-1:0]         shiftNext;
    logic [15:0]                stepsReg;
    logic [PRESCALER_WIDTH-1:0] prescalerReg;
    logic [PRESCALER_WIDTH-1:0] periodShifted;
    logic [PRESCALER_WIDTH-1:0] periodEff;
    logic                       tickHit;
    logic [3:0]                 laneCntReg [LANES];
    logic [3:0]                 laneDivEff [LANES];
    logic [LANES-1:0]           dueVec;

    // Base period from the level; the >= compare lets a level change that
    // shrinks P below the current count produce a tick on the next cycle.
    always_comb begin
        periodShifted = TICK_PERIOD_VEC >> schedBus.SC_BACKGSCHED_level_In;
        if (periodShifted == PRESCALER_ZERO) begin
            periodEff = PRESCALER_ONE;
        end else begin
            periodEff = periodShifted;
        end
        tickHit = (stateReg == RUN) && (prescalerReg >= (periodEff - PRESCALER_ONE));
    end

    // Per-lane effective divider (0 means 1) and due detection on a tick.
    // The >= compare recovers at once if a divider is lowered mid-count.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (schedBus.SC_BACKGSCHED_lanediv_InBUS[4*i +: 4] == 4'd0) begin
                laneDivEff[i] = 4'd1;
            end else begin
                laneDivEff[i] = schedBus.SC_BACKGSCHED_lanediv_InBUS[4*i +: 4];
            end
            dueVec[i] = tickHit && (laneCntReg[i] >= (laneDivEff[i] - 4'd1));
        end
    end

    // Next-state logic; stop has priority over every other request.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (stopReq) begin
                    stateNext = IDLE;
                end else if (startReq) begin
                    stateNext = LOAD;
                end else begin
                    stateNext = IDLE;
                end
            end
            LOAD: begin
                if (stopReq) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (stopReq) begin
                    stateNext = IDLE;
                end else if (pauseReq) begin
                    stateNext = PAUSED;
                end else begin
                    stateNext = RUN;
                end
            end
            PAUSED: begin
                if (stopReq) begin
                    stateNext = IDLE;
                end else if (pauseReq) begin
                    stateNext = PAUSED;
                end else begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Prescaler, lane counters and step counter. A RUN cycle that also
    // requests pause still takes its tick; PAUSED holds everything.
    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            prescalerReg <= PRESCALER_ZERO;
            stepsReg     <= 16'd0;
            for (int i = 0; i < LANES; i++) begin
                laneCntReg[i] <= 4'd0;
            end
        end else if (stopReq || (stateReg == IDLE)) begin
            prescalerReg <= PRESCALER_ZERO;
            stepsReg     <= 16'd0;
            for (int i = 0; i < LANES; i++) begin
                laneCntReg[i] <= 4'd0;
            end
        end else if (stateReg == LOAD) begin
            prescalerReg <= PRESCALER_ZERO;
            for (int i = 0; i < LANES; i++) begin
                laneCntReg[i] <= 4'd0;
            end
        end else if (stateReg == RUN) begin
            if (tickHit) begin
                prescalerReg <= PRESCALER_ZERO;
                stepsReg     <= stepsReg + 16'd1;
                for (int i = 0; i < LANES; i++) begin
                    if (dueVec[i]) begin
                        laneCntReg[i] <= 4'd0;
                    end else begin
                        laneCntReg[i] <= laneCntReg[i] + 4'd1;
                    end
                end
            end else begin
                prescalerReg <= prescalerReg + PRESCALER_ONE;
            end
        end else begin
            prescalerReg <= prescalerReg;
        end
    end

`ifdef SC_BACKGSCHED_ROUNDROBIN_EN
    localparam int PTR_WIDTH = (LANES > 1) ? $clog2(LANES) : 1;

    // Lane index visited k steps after the round-robin pointer.
    function automatic int rrIndex(input int basePtr, input int k);
        return (basePtr + k) % LANES;
    endfunction

    logic [LANES-1:0]     pendingReg;
    logic [LANES-1:0]     pendingNext;
    logic [LANES-1:0]     pendDirReg;
    logic [LANES-1:0]     candVec;
    logic [LANES-1:0]     candDir;
    logic [LANES-1:0]     grantVec;
    logic [PTR_WIDTH-1:0] rrPtrReg;
    logic [PTR_WIDTH-1:0] rrPtrNext;
    logic                 grantFound;
    logic                 laneHit;

    // Round-robin grant over pending lanes plus lanes due this cycle; a lane
    // that becomes due while still pending merges into a single pulse and
    // keeps the most recently sampled direction.
    always_comb begin
        candVec    = pendingReg | dueVec;
        grantVec   = {LANES{1'b0}};
        grantFound = 1'b0;
        laneHit    = 1'b0;
        rrPtrNext  = rrPtrReg;
        shiftNext  = {(2*LANES){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            candDir[i] = dueVec[i] ? dirVec[i] : pendDirReg[i];
        end
        if (stateReg == RUN) begin
            for (int k = 0; k < LANES; k++) begin
                laneHit = candVec[rrIndex(int'(rrPtrReg), k)] && !grantFound;
                grantVec[rrIndex(int'(rrPtrReg), k)] = laneHit;
                rrPtrNext  = laneHit ? PTR_WIDTH'(rrIndex(int'(rrPtrReg), k + 1)) : rrPtrNext;
                grantFound = grantFound | laneHit;
            end
        end else begin
            rrPtrNext = rrPtrReg;
        end
        pendingNext = candVec & ~grantVec;
        for (int i = 0; i < LANES; i++) begin
            if (grantVec[i] && !stopReq) begin
                shiftNext[2*i +: 2] = dirCode(candDir[i]);
            end else begin
                shiftNext[2*i +: 2] = 2'b00;
            end
        end
    end

    // Pending flags, their directions and the round-robin pointer.
    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            pendingReg <= {LANES{1'b0}};
            pendDirReg <= {LANES{1'b0}};
            rrPtrReg   <= {PTR_WIDTH{1'b0}};
        end else if (stopReq || (stateReg == IDLE) || (stateReg == LOAD)) begin
            pendingReg <= {LANES{1'b0}};
            pendDirReg <= {LANES{1'b0}};
            rrPtrReg   <= {PTR_WIDTH{1'b0}};
        end else if (stateReg == RUN) begin
            pendingReg <= pendingNext;
            pendDirReg <= candDir;
            rrPtrReg   <= rrPtrNext;
        end else begin
            pendingReg <= pendingReg;
        end
    end
`else
    // Every lane due on this tick shifts at once; stop drops the pulses.
    always_comb begin
        shiftNext = {(2*LANES){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (dueVec[i] && !stopReq) begin
                shiftNext[2*i +: 2] = dirCode(dirVec[i]);
            end else begin
                shiftNext[2*i +: 2] = 2'b00;
            end
        end
    end
`endif

    // Registered strobes and shift selections. Strobes follow the state being
    // entered so they line up with the registered state output.
    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            clearReg <= 1'b0;
            loadReg  <= 1'b1;
            shiftReg <= {(2*LANES){1'b0}};
        end else begin
            clearReg <= (stateNext != IDLE);
            loadReg  <= (stateNext != LOAD);
            shiftReg <= shiftNext;
        end
    end

    assign schedBus.SC_BACKGSCHED_clear_OutLow          = clearReg;
    assign schedBus.SC_BACKGSCHED_load_OutLow           = loadReg;
    assign schedBus.SC_BACKGSCHED_shiftselection_OutBUS = shiftReg;
    assign schedBus.SC_BACKGSCHED_state_Out             = stateReg;
    assign schedBus.SC_BACKGSCHED_steps_Out             = stepsReg;

endmodule

// File: tb/tb_sc_backg_lane_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sc_backg_lane_scheduler
//
// Directed bench for sc_backg_lane_scheduler with TICK_PERIOD = 8.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sc_backg_lane_scheduler;

    localparam int LANES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assertCount = 0;
    int   failCount   = 0;

    // Expected shift bus on ticks 1..4 of the mixed-divider run.
    logic [7:0] tableB [4] = '{8'h21, 8'h25, 8'h21, 8'h65};

    sc_backg_lane_scheduler_if #(.LANES(LANES)) schedBus ();

    sc_backg_lane_scheduler #(
        .LANES          (LANES),
        .TICK_PERIOD    (8),
        .PRESCALER_WIDTH(32)
    ) dut (
        .SC_RegBACKGTYPE_CLOCK_50    (clk),
        .SC_RegBACKGTYPE_RESET_InHigh(rst),
        .schedBus                    (schedBus.slave)
    );

    always #10 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkEq({tag, "_state"}, 32'(schedBus.SC_BACKGSCHED_state_Out), 32'd0);
        checkEq({tag, "_clear"}, 32'(schedBus.SC_BACKGSCHED_clear_OutLow), 32'd0);
        checkEq({tag, "_load"},  32'(schedBus.SC_BACKGSCHED_load_OutLow), 32'd1);
        checkEq({tag, "_shift"}, 32'(schedBus.SC_BACKGSCHED_shiftselection_OutBUS), 32'd0);
        checkEq({tag, "_steps"}, 32'(schedBus.SC_BACKGSCHED_steps_Out), 32'd0);
    endtask

    // Start from IDLE; returns at the falling edge right after RUN entry.
    task automatic startRun(input string tag);
        schedBus.SC_BACKGSCHED_start_InHigh = 1'b1;
        @(negedge clk);
        schedBus.SC_BACKGSCHED_start_InHigh = 1'b0;
        checkEq({tag, "_load_state"}, 32'(schedBus.SC_BACKGSCHED_state_Out), 32'd1);
        checkEq({tag, "_load_strobe"}, 32'(schedBus.SC_BACKGSCHED_load_OutLow), 32'd0);
        checkEq({tag, "_load_clear"}, 32'(schedBus.SC_BACKGSCHED_clear_OutLow), 32'd1);
        @(negedge clk);
        checkEq({tag, "_run_state"}, 32'(schedBus.SC_BACKGSCHED_state_Out), 32'd2);
        checkEq({tag, "_run_load"}, 32'(schedBus.SC_BACKGSCHED_load_OutLow), 32'd1);
    endtask

    task automatic stopRun(input string tag);
        schedBus.SC_BACKGSCHED_stop_InHigh = 1'b1;
        @(negedge clk);
        schedBus.SC_BACKGSCHED_stop_InHigh = 1'b0;
        checkIdle(tag);
    endtask

    initial begin
        logic [31:0] expShift;
        schedBus.SC_BACKGSCHED_start_InHigh  = 1'b0;
        schedBus.SC_BACKGSCHED_stop_InHigh   = 1'b0;
        schedBus.SC_BACKGSCHED_pause_InHigh  = 1'b0;
        schedBus.SC_BACKGSCHED_level_In      = 2'd0;
        schedBus.SC_BACKGSCHED_direction_In  = 4'b0000;
        schedBus.SC_BACKGSCHED_lanediv_InBUS = 16'h0000;

        // Reset values.
        repeat (3) @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;
        @(negedge clk);
        checkIdle("idle_hold");

        // start and stop together in IDLE: stays IDLE.
        schedBus.SC_BACKGSCHED_start_InHigh = 1'b1;
        schedBus.SC_BACKGSCHED_stop_InHigh  = 1'b1;
        @(negedge clk);
        schedBus.SC_BACKGSCHED_start_InHigh = 1'b0;
        schedBus.SC_BACKGSCHED_stop_InHigh  = 1'b0;
        checkIdle("start_stop");

        // P=8; lane0 div1 L, lane1 div2 L, lane2 div0 (=1) R, lane3 div4 L.
        schedBus.SC_BACKGSCHED_level_In      = 2'd0;
        schedBus.SC_BACKGSCHED_direction_In  = 4'b0100;
        schedBus.SC_BACKGSCHED_lanediv_InBUS = 16'h4021;
        startRun("B");
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            expShift = ((c % 8) == 0) ? 32'(tableB[(c / 8) - 1]) : 32'd0;
            checkEq("B_shift", 32'(schedBus.SC_BACKGSCHED_shiftselection_OutBUS), expShift);
            checkEq("B_steps", 32'(schedBus.SC_BACKGSCHED_steps_Out), 32'(c / 8));
        end
        stopRun("B_stop");

        // level 2 -> P=2; lane1 div3 right shifts every 6 clocks.
        schedBus.SC_BACKGSCHED_level_In      = 2'd2;
        schedBus.SC_BACKGSCHED_direction_In  = 4'b0010;
        schedBus.SC_BACKGSCHED_lanediv_InBUS = 16'hFF3F;
        startRun("C");
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            expShift = ((c % 6) == 0) ? 32'h08 : 32'd0;
            checkEq("C_shift", 32'(schedBus.SC_BACKGSCHED_shiftselection_OutBUS), expShift);
            checkEq("C_steps", 32'(schedBus.SC_BACKGSCHED_steps_Out), 32'(c / 2));
        end
        // start during RUN is ignored.
        schedBus.SC_BACKGSCHED_start_InHigh = 1'b1;
        @(negedge clk);
        schedBus.SC_BACKGSCHED_start_InHigh = 1'b0;
        checkEq("C_start_state", 32'(schedBus.SC_BACKGSCHED_state_Out), 32'd2);
        checkEq("C_start_load", 32'(schedBus.SC_BACKGSCHED_load_OutLow), 32'd1);
        checkEq("C_start_steps", 32'(schedBus.SC_BACKGSCHED_steps_Out), 32'd10);
        stopRun("C_stop");

        // Pause mid-RUN at prescaler 3 (P=8, lane0 div1 left).
        schedBus.SC_BACKGSCHED_level_In      = 2'd0;
        schedBus.SC_BACKGSCHED_direction_In  = 4'b0000;
        schedBus.SC_BACKGSCHED_lanediv_InBUS = 16'hFFF1;
        startRun("D");
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            expShift = (c == 8) ? 32'h01 : 32'd0;
            checkEq("D_shift", 32'(schedBus.SC_BACKGSCHED_shiftselection_OutBUS), expShift);
        end
        schedBus.SC_BACKGSCHED_pause_InHigh = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            checkEq("D_paused_state", 32'(schedBus.SC_BACKGSCHED_state_Out), 32'd3);
            checkEq("D_paused_shift", 32'(schedBus.SC_BACKGSCHED_shiftselection_OutBUS), 32'd0);
            checkEq("D_paused_steps", 32'(schedBus.SC_BACKGSCHED_steps_Out), 32'd1);
        end
        schedBus.SC_BACKGSCHED_pause_InHigh = 1'b0;
        @(negedge clk);
        checkEq("D_resume_state", 32'(schedBus.SC_BACKGSCHED_state_Out), 32'd2);
        // Prescaler froze at 4, so the next pulse is 4 clocks after resuming.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            expShift = (k == 4) ? 32'h01 : 32'd0;
            checkEq("D_resume_shift", 32'(schedBus.SC_BACKGSCHED_shiftselection_OutBUS), expShift);
            checkEq("D_resume_steps", 32'(schedBus.SC_BACKGSCHED_steps_Out), (k == 4) ? 32'd2 : 32'd1);
        end
        stopRun("D_stop");

        // All four lanes div1 left.
        schedBus.SC_BACKGSCHED_lanediv_InBUS = 16'h1111;
        startRun("F");
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
`ifdef SC_BACKGSCHED_ROUNDROBIN_EN
            expShift = ((c >= 8) && ((c % 8) < 4)) ? (32'h01 << (2 * (c % 8))) : 32'd0;
`else
            expShift = ((c % 8) == 0) ? 32'h55 : 32'd0;
`endif
            checkEq("F_shift", 32'(schedBus.SC_BACKGSCHED_shiftselection_OutBUS), expShift);
        end
        checkEq("F_steps", 32'(schedBus.SC_BACKGSCHED_steps_Out), 32'd2);

        // Reset mid-RUN.
        rst = 1'b1;
        @(negedge clk);
        checkIdle("reset_run");
        rst = 1'b0;
        @(negedge clk);
        checkIdle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
